// File: rtl/instr_encoder_pkg.sv
// Shared constants for the instruction encoder.
// Opcodes match the control-path decoder, so words built here decode back
// to the same instruction class. Also holds the request class codes and the
// fixed funct3 values for LW, SW and BEQ.
package instr_encoder_pkg;

  localparam logic [6:0] OP_NOP   = 7'b0000000;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_R     = 3'd1,
    CLS_I     = 3'd2,
    CLS_LOAD  = 3'd3,
    CLS_STORE = 3'd4,
    CLS_BEQ   = 3'd5,
    CLS_ILL6  = 3'd6,
    CLS_ILL7  = 3'd7
  } instr_class_e;

endpackage

// File: rtl/instr_encoder_fifo.sv
// sync_fifo: single-clock FIFO with one push and one pop port.
// Ports: clk_i/rst_i (sync, active-high), push_i/wdata_i, pop_i/rdata_o
// (head, valid when !empty_o), full_o, empty_o.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit tells full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata_o = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i && !empty_o) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !rst_i) mem[wr_ptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level instruction requests into 32-bit RISC-V
// words. Each word is queued together with its instruction-memory byte
// address.
// Ports: req_valid_i/req_ready_o handshake with class_i, rd_i, rs1_i, rs2_i,
// funct3_i, funct7_i and imm_i. word_valid_o/word_ready_i handshake with
// word_o and addr_o. err_o is a sticky flag for illegal requests. count_o
// counts delivered words.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  class_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [12:0] imm_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic [15:0] count_o
);

  function automatic logic [31:0] encode(
    input instr_class_e c,
    input logic [4:0]   rd,
    input logic [4:0]   rs1,
    input logic [4:0]   rs2,
    input logic [2:0]   f3,
    input logic [6:0]   f7,
    input logic [12:0]  imm
  );
    logic [31:0] w;
    w = {25'b0, OP_NOP};
    case (c)
      CLS_R:     w = {f7, rs2, rs1, f3, rd, OP_R};
      CLS_I:     w = {imm[11:0], rs1, f3, rd, OP_I};
      CLS_LOAD:  w = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
      CLS_STORE: w = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
      CLS_BEQ:   w = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BEQ};
      default:   w = {25'b0, OP_NOP};
    endcase
    return w;
  endfunction

  instr_class_e cls;
  logic         full;
  logic         empty;
  logic         accept;
  logic         bad;
  logic         push;
  logic         pop;
  logic [31:0]  next_addr;
  logic         err_q;
  logic [15:0]  count_q;
  logic [63:0]  head;

  assign cls = instr_class_e'(class_i);

  always_comb begin
    bad = 1'b0;
    case (cls)
      CLS_ILL6, CLS_ILL7: bad = 1'b1;
      CLS_BEQ:            bad = imm_i[0];
      default:            bad = 1'b0;
    endcase
  end

  // No pop-through: a full FIFO refuses requests even if the head leaves now.
  assign req_ready_o = !rst_i && !full;
  assign accept      = req_valid_i && req_ready_o;
  assign push        = accept && !bad;

  // Outputs are forced quiet during reset, before the synchronous clear lands.
  assign word_valid_o = !rst_i && !empty;
  assign pop          = word_valid_o && word_ready_i;
  assign word_o       = word_valid_o ? head[63:32] : '0;
  assign addr_o       = word_valid_o ? head[31:0]  : '0;
  assign err_o        = !rst_i && err_q;
  assign count_o      = rst_i ? '0 : count_q;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i ({encode(cls, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i), next_addr}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      next_addr <= BASE_ADDR;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push)         next_addr <= next_addr + 32'd4;
      if (accept && bad) err_q    <= 1'b1;
      if (pop)          count_q   <= count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  class_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [12:0] imm_i;
  logic        word_valid_o;
  logic        word_ready_i;
  logic [31:0] word_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic [15:0] count_o;

  instr_encoder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .class_i      (class_i),
    .rd_i         (rd_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .funct3_i     (funct3_i),
    .funct7_i     (funct7_i),
    .imm_i        (imm_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_o       (word_o),
    .addr_o       (addr_o),
    .err_o        (err_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state: queue of {word, addr}, next address, error, delivered count.
  logic [63:0] m_q[$];
  logic [31:0] m_addr  = BASE_ADDR;
  bit          m_err   = 1'b0;
  logic [15:0] m_count = '0;
  bit          m_acc   = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction word built from the ISA field layout with shifts and masks.
  function automatic logic [31:0] ref_enc(input logic [2:0] c, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [12:0] imm13);
    int unsigned imm, r_d, r_s1, r_s2, fn3, fn7;
    imm = 32'(imm13); r_d = 32'(rd); r_s1 = 32'(rs1); r_s2 = 32'(rs2);
    fn3 = 32'(f3); fn7 = 32'(f7);
    case (c)
      3'd1: return (fn7 << 25) | (r_s2 << 20) | (r_s1 << 15) | (fn3 << 12) | (r_d << 7) | 32'h33;
      3'd2: return ((imm & 32'hFFF) << 20) | (r_s1 << 15) | (fn3 << 12) | (r_d << 7) | 32'h13;
      3'd3: return ((imm & 32'hFFF) << 20) | (r_s1 << 15) | (32'd2 << 12) | (r_d << 7) | 32'h03;
      3'd4: return (((imm >> 5) & 32'h7F) << 25) | (r_s2 << 20) | (r_s1 << 15) | (32'd2 << 12)
                   | ((imm & 32'h1F) << 7) | 32'h23;
      3'd5: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (r_s2 << 20)
                   | (r_s1 << 15) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      default: return 32'h0;
    endcase
  endfunction

  task automatic compare_all();
    bit v;
    v = !rst_i && (m_q.size() > 0);
    check_val("req_ready", 64'(req_ready_o), 64'(!rst_i && (m_q.size() < DEPTH)));
    check_val("word_valid", 64'(word_valid_o), 64'(v));
    check_val("word", 64'(word_o), v ? 64'(m_q[0][63:32]) : 64'h0);
    check_val("addr", 64'(addr_o), v ? 64'(m_q[0][31:0]) : 64'h0);
    check_val("err", 64'(err_o), 64'(!rst_i && m_err));
    check_val("count", 64'(count_o), rst_i ? 64'h0 : 64'(m_count));
  endtask

  // Entered just after a falling edge: drive, advance one cycle, check.
  task automatic step(input bit v, input logic [2:0] c, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [12:0] imm, input bit wr, input bit rst);
    bit rdy, vld, pop, acc, bad;
    req_valid_i = v; class_i = c; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm; word_ready_i = wr; rst_i = rst;
    rdy = !rst && (m_q.size() < DEPTH);
    vld = !rst && (m_q.size() > 0);
    pop = vld && wr;
    acc = v && rdy;
    bad = (c > 3'd5) || (c == 3'd5 && imm[0]);
    @(posedge clk_i);
    if (rst) begin
      m_q.delete(); m_addr = BASE_ADDR; m_err = 1'b0; m_count = '0; m_acc = 1'b0;
    end else begin
      if (pop) begin void'(m_q.pop_front()); m_count++; end
      if (acc) begin
        if (bad) m_err = 1'b1;
        else begin
          m_q.push_back({ref_enc(c, rd, rs1, rs2, f3, f7, imm), m_addr});
          m_addr += 32'd4;
        end
      end
      m_acc = acc;
    end
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic idle(input bit wr, input bit rst);
    step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, wr, rst);
  endtask

  task automatic do_reset();
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] seen[$];
    bit          got5;
    rst_i = 1'b1; req_valid_i = 1'b0; word_ready_i = 1'b0; class_i = '0;
    rd_i = '0; rs1_i = '0; rs2_i = '0; funct3_i = '0; funct7_i = '0; imm_i = '0;
    @(negedge clk_i);

    // Reset values
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    check_val("rst_valid", 64'(word_valid_o), 64'h0);
    check_val("rst_ready", 64'(req_ready_o), 64'h0);
    idle(1'b0, 1'b0);
    check_val("post_rst_ready", 64'(req_ready_o), 64'h1);

    // R add x3,x1,x2
    step(1'b1, 3'd1, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, 1'b0);
    check_val("r_add_word", 64'(word_o), 64'h002081B3);
    check_val("r_add_addr", 64'(addr_o), 64'h0);
    idle(1'b1, 1'b0);
    check_val("r_add_count", 64'(count_o), 64'h1);

    // LOAD then STORE back-to-back
    do_reset();
    step(1'b1, 3'd3, 5'd5, 5'd2, 5'd0, 3'd7, 7'h7F, 13'd8, 1'b1, 1'b0);
    check_val("lw_word", 64'(word_o), 64'h00812283);
    check_val("lw_addr", 64'(addr_o), 64'h0);
    step(1'b1, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd12, 1'b1, 1'b0);
    check_val("sw_word", 64'(word_o), 64'h0020A623);
    check_val("sw_addr", 64'(addr_o), 64'h4);

    // BEQ with negative offset, then NOP
    do_reset();
    step(1'b1, 3'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8, 1'b1, 1'b0);
    check_val("beq_word", 64'(word_o), 64'hFE208CE3);
    check_val("beq_addr", 64'(addr_o), 64'h0);
    step(1'b1, 3'd0, 5'd9, 5'd9, 5'd9, 3'd1, 7'd1, 13'd3, 1'b1, 1'b0);
    check_val("nop_word", 64'(word_o), 64'h0);
    check_val("nop_addr", 64'(addr_o), 64'h4);

    // Fill the FIFO with the consumer stalled; fifth request must wait
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 3'd1, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0, 1'b0);
    check_val("full_ready", 64'(req_ready_o), 64'h0);
    step(1'b1, 3'd1, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0, 1'b0);
    check_val("held_ready", 64'(req_ready_o), 64'h0);
    check_val("held_word", 64'(word_o), 64'h002080B3);
    check_val("held_addr", 64'(addr_o), 64'h0);
    got5 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (word_valid_o) seen.push_back(addr_o);
      step(!got5, 3'd1, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, 1'b0);
      if (m_acc) got5 = 1'b1;
    end
    check_val("drain_len", 64'(seen.size()), 64'd5);
    for (int i = 0; i < seen.size() && i < 5; i++)
      check_val($sformatf("drain_addr%0d", i), 64'(seen[i]), 64'(4 * i));

    // Illegal class and misaligned BEQ
    do_reset();
    step(1'b1, 3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0, 1'b1, 1'b0);
    check_val("ill_valid", 64'(word_valid_o), 64'h0);
    check_val("ill_err", 64'(err_o), 64'h1);
    step(1'b1, 3'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0005, 1'b1, 1'b0);
    check_val("beq_odd_valid", 64'(word_valid_o), 64'h0);
    step(1'b1, 3'd2, 5'd4, 5'd3, 5'd0, 3'd0, 7'd0, 13'd1, 1'b0, 1'b0);
    check_val("after_err_addr", 64'(addr_o), 64'h0);
    check_val("after_err_err", 64'(err_o), 64'h1);

    // Reset with words queued
    do_reset();
    step(1'b1, 3'd1, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 5'd2, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 1'b1, 1'b0);
    idle(1'b1, 1'b1);
    check_val("midrst_valid", 64'(word_valid_o), 64'h0);
    idle(1'b0, 1'b0);
    step(1'b1, 3'd1, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0, 1'b0);
    check_val("midrst_addr", 64'(addr_o), 64'(BASE_ADDR));
    check_val("midrst_err", 64'(err_o), 64'h0);
    check_val("midrst_count", 64'(count_o), 64'h0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
           5'($urandom), 3'($urandom), 7'($urandom), 13'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V instruction encoder for the project CPU, the inverse of the opcode decoder in the control path. It accepts field-level instruction requests (class, registers, funct, immediate) over a valid/ready handshake. It packs each request into a 32-bit instruction word and queues it in a small FIFO. It emits words with their instruction-memory byte addresses to the program loader and the testbench stimulus path.

## Interface
- DEPTH, 4: output FIFO entries (power of two, ≥2)
- BASE_ADDR, 32'h0: byte address assigned to the first word after reset
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  encoder can accept a request
- class_i  in  3  0 NOP, 1 R, 2 I, 3 LOAD, 4 STORE, 5 BEQ, 6/7 illegal
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- funct3_i  in  3  used by R and I only
- funct7_i  in  7  used by R only
- imm_i  in  13  immediate, two's complement; bits [11:0] for I/LOAD/STORE, [12:0] for BEQ
- word_valid_o  out  1  FIFO head valid
- word_ready_i  in  1  consumer takes head
- word_o  out  32  encoded instruction at head
- addr_o  out  32  byte address of head word
- err_o  out  1  sticky error flag
- count_o  out  16  words delivered (completed output handshakes), wraps

## Operation
- Accept when req_valid_i && req_ready_o. req_ready_o = !rst_i && FIFO not full. There is no pop-through when full.
- Encoding, with opcodes matching the control decoder:
  - NOP: 32'h0000_0000
  - R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}
  - I: {imm[11:0], rs1, funct3, rd, 7'b0010011}
  - LOAD: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}. funct3_i is ignored.
  - STORE: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}
- Fields unused by a class are ignored. The word does not depend on them.
- Error cases, which accept and drop the request: class 6/7, or BEQ with imm_i[0]=1. No word is pushed, the address does not advance, and err_o is set. err_o clears only on reset.
- Address counter:
  - Starts at BASE_ADDR.
  - Each pushed word captures the current value, and the counter then adds 4.
  - Wraps modulo 2^32.
  - addr_o travels with its word through the FIFO.
- Output: word_o and addr_o stay stable while word_valid_o && !word_ready_i. count_o increments on each output handshake.
- Simultaneous push and pop with the FIFO not full: both occur, and occupancy is unchanged.

## Timing
- Latency: a request accepted at cycle N is visible on word_o at N+1 if the FIFO was empty. Otherwise it is queued behind older words in order.
- Throughput: one word per cycle when word_ready_i is held high.
- req_ready_o drops in the cycle the FIFO holds DEPTH entries. It rises the cycle after a pop frees a slot.
- Values during reset and in the first cycle after it:
  - While rst_i is high: word_valid_o=0, word_o=0, addr_o=0, err_o=0, count_o=0, req_ready_o=0.
  - First cycle after reset: req_ready_o=1.
- Reset mid-operation: the FIFO is flushed (queued words are lost), the address counter returns to BASE_ADDR, and err_o and count_o are cleared.
- err_o rises the cycle after the offending acceptance.

## Structure
- Shared package:
  - opcode constants OP_NOP, OP_R, OP_I, OP_LOAD, OP_STORE, OP_BEQ, identical to those used by the control decoder
  - class codes
  - funct3 constants for LW/SW/BEQ
- Sub-module sync_fifo (DEPTH, width 64 = word+addr): full/empty flags, one push and one pop port, synchronous reset.
- Encoding is a combinational function in the top level. Address counter, error flag and count_o also live in the top level.

## Test plan
- R add x3,x1,x2 (funct7 0, funct3 0), word_ready_i=1 → next cycle word_o=32'h002081B3, addr_o=0, then count_o=1.
- LOAD rd=5, rs1=2, imm=8, then STORE rs2=2, rs1=1, imm=12 back-to-back → word_o=32'h00812283 @0, then 32'h0020A623 @4.
- BEQ rs1=1, rs2=2, imm=-8 → word_o=32'hFE208CE3. NOP → 32'h00000000. Addresses are consecutive.
- word_ready_i=0, five requests offered:
  - req_ready_o goes low after the 4th acceptance, and the 5th is held.
  - word_o stays stable.
  - After release: words arrive in order at addrs 0,4,8,12, then the 5th at 16.
- class 7, then BEQ with imm=13'h0005 → no word for either, err_o=1, and the next valid request gets addr 0.
- Two words queued, rst_i pulsed one cycle → word_valid_o=0 during reset. The next request gets addr_o=BASE_ADDR, and err_o=0, count_o=0.
